uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: Parameter CLKS_PER_BIT, default 14, SHALL set the clocks per serial bit period, matching the transmitter.
REQ-002: Parameter SAMPLE_POINT, default 6, SHALL set the counter value at which each bit is sampled (mid-bit).
REQ-003: clk_3125_rx  input  1  SHALL be the single receive clock; all logic SHALL be rising-edge.
REQ-004: rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005: rx  input  1  SHALL be the asynchronous serial line, idle high.
REQ-006: parity_type  input  1  SHALL select parity: 0 = even, 1 = odd; expected parity = (^data) ^ parity_type.
REQ-007: rx_msg  output  8  SHALL hold the last received data byte.
REQ-008: rx_parity  output  1  SHALL hold the last received parity bit.
REQ-009: rx_complete  output  1  SHALL be a one-cycle pulse marking a new frame on rx_msg.
REQ-010: parity_err  output  1  SHALL flag a parity mismatch in the last frame.
REQ-011: frame_err  output  1  SHALL flag a low stop bit in the last frame.

Function
REQ-012: Frame format SHALL be 1 start bit (0), 8 data bits MSB first, 1 parity bit, 1 stop bit (1).
REQ-013: rx SHALL pass through a 2-flop synchronizer (rx_s1, rx_s2) before any use; the FSM SHALL use rx_s2 only.
REQ-014: FSM states: IDLE, START, DATA, PARITY, STOP; 4-bit clk_cnt and 3-bit bit_idx.
REQ-015: IDLE: start SHALL be detected only on a falling edge (rx_prev=1, rx_s2=0); then go to START with clk_cnt=0.
REQ-016: START: at clk_cnt==SAMPLE_POINT, rx_s2=1 SHALL count as a false start and return to IDLE with no outputs changed.
REQ-017: START: at clk_cnt==CLKS_PER_BIT-1, go to DATA with clk_cnt=0 and bit_idx=7.
REQ-018: DATA: at clk_cnt==SAMPLE_POINT, load rx_s2 into shift_reg[bit_idx].
REQ-019: DATA: at clk_cnt==CLKS_PER_BIT-1, if bit_idx==0 go to PARITY, else decrement bit_idx; clk_cnt wraps to 0.
REQ-020: PARITY: sample rx_s2 into par_reg at SAMPLE_POINT; go to STOP at CLKS_PER_BIT-1.
REQ-021: STOP: at SAMPLE_POINT, in one cycle, load rx_msg=shift_reg, rx_parity=par_reg, parity_err=(^shift_reg ^ parity_type) != par_reg, frame_err=~rx_s2, pulse rx_complete=1, and go to IDLE.
REQ-022: Returning to IDLE at the stop-bit midpoint SHALL allow a back-to-back start bit with zero idle gap to be detected.
REQ-023: After a frame error the line stays low, so REQ-015 SHALL block any new start until rx_s2 has been high at least one cycle.
REQ-024: A frame with an error SHALL still update rx_msg and pulse rx_complete, with the flag set.
REQ-025: rx_msg, rx_parity, parity_err and frame_err SHALL hold their values until the next rx_complete or rst.
REQ-026: Latency: if k is the first clock edge sampling rx=0, rx_complete SHALL be high in the cycle after edge k+149.
REQ-027: Consistent with REQ-026, consecutive rx_complete pulses for frames sent back to back SHALL be 154 cycles apart.
REQ-028: parity_type SHALL be read only at the stop-bit sample and SHALL be held stable for the whole frame.

Reset
REQ-029: With rst=1 at a clock edge, state SHALL go to IDLE; clk_cnt, bit_idx, shift_reg, par_reg, rx_msg, rx_parity, rx_complete, parity_err and frame_err SHALL go to 0; rx_s1, rx_s2 and rx_prev SHALL go to 1.
REQ-030: rst asserted mid-frame SHALL abort the frame with no rx_complete pulse; reception SHALL resume only on the next falling edge after rst deasserts.

Verification
REQ-031: parity_type=0, send 0xA5 with parity 0 and stop 1 -> single rx_complete pulse at k+150, rx_msg=0xA5, rx_parity=0, parity_err=0, frame_err=0.
REQ-032: parity_type=1, send 0x3C with corrupted parity bit 0 (correct is 1) -> rx_msg=0x3C, parity_err=1, frame_err=0.
REQ-033: Send 0x81 with stop bit 0, then hold rx low 50 cycles -> frame_err=1, rx_msg=0x81, and no further rx_complete until rx returns high and falls again.
REQ-034: Drive a 3-cycle low glitch on idle rx -> false start, no rx_complete, outputs unchanged.
REQ-035: Send 0x00, 0xFF, 0x5A back to back with no gap -> three pulses 154 cycles apart with correct bytes and no error flags.
REQ-036: Assert rst for 1 cycle during data bit 4 of 0x77, then send 0x12 -> no pulse for 0x77, exactly one pulse with rx_msg=0x12.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, parity select and received-frame results of the UART receiver
interface uart_rx_if;
  logic       rx;
  logic       parity_type;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_complete;
  logic       parity_err;
  logic       frame_err;
  modport master (output rx, parity_type, input rx_msg, rx_parity, rx_complete, parity_err, frame_err);
  modport slave  (input rx, parity_type, output rx_msg, rx_parity, rx_complete, parity_err, frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8-bit MSB-first UART receiver with parity and stop-bit checking
module uart_rx #(
  parameter int CLKS_PER_BIT = 14,
  parameter int SAMPLE_POINT = 6
) (
  input logic    clk_3125_rx,
  input logic    rst,
  uart_rx_if.slave u
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [3:0] SP   = 4'(SAMPLE_POINT);
  localparam logic [3:0] LAST = 4'(CLKS_PER_BIT - 1);
  state_t     state;
  logic [3:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       par_reg;
  logic       rx_s1, rx_s2, rx_prev;
  always_ff @(posedge clk_3125_rx) begin
    if (rst) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      par_reg       <= 1'b0;
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      u.rx_msg      <= '0;
      u.rx_parity   <= 1'b0;
      u.rx_complete <= 1'b0;
      u.parity_err  <= 1'b0;
      u.frame_err   <= 1'b0;
    end else begin
      rx_s1         <= u.rx;
      rx_s2         <= rx_s1;
      rx_prev       <= rx_s2;
      u.rx_complete <= 1'b0;
      case (state)
        IDLE: if (rx_prev && !rx_s2) begin
          state   <= START;
          clk_cnt <= '0;
        end
        START: begin
          if (clk_cnt == SP && rx_s2) state <= IDLE;
          else if (clk_cnt == LAST) begin
            state   <= DATA;
            clk_cnt <= '0;
            bit_idx <= 3'd7;
          end else clk_cnt <= clk_cnt + 4'd1;
        end
        DATA: begin
          if (clk_cnt == SP) shift_reg[bit_idx] <= rx_s2;
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd0) state <= PARITY;
            else bit_idx <= bit_idx - 3'd1;
          end else clk_cnt <= clk_cnt + 4'd1;
        end
        PARITY: begin
          if (clk_cnt == SP) par_reg <= rx_s2;
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            state   <= STOP;
          end else clk_cnt <= clk_cnt + 4'd1;
        end
        STOP: begin
          // leave at mid stop bit so a zero-gap start bit is still seen as a falling edge
          if (clk_cnt == SP) begin
            u.rx_msg      <= shift_reg;
            u.rx_parity   <= par_reg;
            u.parity_err  <= (^shift_reg ^ u.parity_type) != par_reg;
            u.frame_err   <= ~rx_s2;
            u.rx_complete <= 1'b1;
            state         <= IDLE;
          end else clk_cnt <= clk_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
